fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control FSM that drives the fetch stage's `fetch_en`, `isBranchTaken` and `branchPC` inputs. It sequences start-up, normal fetch, hazard stalls, branch redirects with a wrong-path squash window, and HALT detection. It sits between the fetch unit and the decode/execute stages. It also keeps saturating performance counters for stall cycles and redirects.

## Interface
- INSTR_WIDTH, 32, instruction/PC width
- OPCODE_W, 5, opcode field width; opcode = `instr_in[INSTR_WIDTH-1 -: OPCODE_W]`
- HALT_OPCODE, 5'h1F, opcode that stops fetching
- BOOT_CYCLES, 4, idle cycles after `start` before the first fetch (≥1)
- FLUSH_CYCLES, 2, cycles `squash` stays high per redirect (≥1)
- CNT_W, 16, performance counter width

- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin/restart execution; honoured in IDLE and HALT only
- stall_req  in  1  downstream hazard; hold fetch
- branch_req  in  1  execute stage resolved a taken branch
- branch_target  in  INSTR_WIDTH  redirect PC, valid with `branch_req`
- instr_valid  in  1  `instr_in` holds a real fetched instruction
- instr_in  in  INSTR_WIDTH  fetch-stage instruction output
- fetch_en  out  1  to fetch unit
- isBranchTaken  out  1  to fetch unit; one-cycle redirect pulse
- branchPC  out  INSTR_WIDTH  to fetch unit
- squash  out  1  to decode/execute: discard the current instruction
- halted  out  1  HALT reached
- busy  out  1  state is not IDLE and not HALT
- stall_count  out  CNT_W  stall cycles, saturating
- flush_count  out  CNT_W  redirects taken, saturating

## Operation
- All outputs are registered. `rst`=0 at an edge gives state IDLE and all outputs 0, including the counters. Reset mid-operation aborts at that edge with no partial update.
- IDLE: `fetch_en`=0. `start` loads cnt=BOOT_CYCLES-1, clears both counters, clears `halted`, and moves to BOOT.
- BOOT: `fetch_en`=0. While cnt≠0, cnt decrements. At cnt=0 the FSM moves to RUN with `fetch_en`<=1. Other inputs are ignored.
- RUN: `fetch_en`=1. Evaluated in priority order each edge:
  1. `branch_req`: `isBranchTaken`<=1, `branchPC`<=`branch_target`, `squash`<=1, cnt=FLUSH_CYCLES-1, `flush_count`++, go to FLUSH.
  2. `instr_valid` and opcode==HALT_OPCODE: `fetch_en`<=0, `halted`<=1, go to HALT.
  3. `stall_req`: `fetch_en`<=0, `stall_count`++, go to STALL.
- STALL: `fetch_en`=0.
  - `branch_req` has priority and is handled exactly as in RUN; `fetch_en`<=1.
  - Otherwise, `stall_req`=1 keeps STALL and increments `stall_count`.
  - `stall_req`=0 returns to RUN with `fetch_en`<=1.
  - HALT detection is inactive.
- FLUSH: `fetch_en`=1, `isBranchTaken`<=0 on the first FLUSH edge. If cnt≠0, cnt decrements; otherwise `squash`<=0 and the FSM moves to RUN. `branch_req`, `stall_req` and HALT opcodes are ignored because they are wrong-path.
- HALT: `fetch_en`=0, `halted`=1. `start` behaves as in IDLE. All other inputs are ignored.
- `branchPC` holds its last value except when a redirect is taken.
- Counters saturate at all-ones; they never wrap.

## Timing
- With `start` sampled at edge S, `fetch_en` goes to 1 after edge S+BOOT_CYCLES.
- With a redirect sampled at edge R:
  - `isBranchTaken`=1 for exactly the one cycle after R.
  - `squash`=1 for exactly FLUSH_CYCLES cycles after R.
  - `fetch_en` stays 1 throughout.
- Stall response: `stall_req` sampled at edge E drops `fetch_en` after E. Fetch resumes one cycle after `stall_req` is sampled low.
- Simultaneous inputs:
  - `branch_req` with `stall_req`, or `branch_req` with HALT: the branch wins.
  - `start` with `rst`=0: reset wins.
- `busy` is 1 in BOOT, RUN, STALL and FLUSH.

## Test plan
- Reset/boot: hold `rst`=0 for 3 cycles → all outputs 0. Release, pulse `start` at edge 0 → `fetch_en` rises after edge 4 and `busy`=1 from edge 0.
- Redirect: in RUN, `branch_req`=1 with `branch_target`=0x40 for one cycle → `isBranchTaken`=1 and `branchPC`=0x40 for 1 cycle, `squash`=1 for 2 cycles, `flush_count`=1.
- Stall: `stall_req` high for 5 cycles → `fetch_en`=0 for 5 cycles, `stall_count`=5, `fetch_en`=1 the cycle after release. During FLUSH, `stall_req` gives `stall_count` unchanged.
- Priority: `branch_req`, `stall_req` and a HALT opcode with `instr_valid` all asserted together in RUN → redirect taken, `halted`=0. The HALT opcode during FLUSH is ignored.
- Halt/restart: `instr_in`=0xF800_0000 with `instr_valid`=1 → `halted`=1, `fetch_en`=0, `busy`=0. Then `start` → `halted`=0, counters cleared, `fetch_en` high 4 cycles later.
- Saturation/reset mid-op: with CNT_W=4, hold `stall_req` for 20 cycles → `stall_count`=0xF. Assert `rst`=0 during STALL → next edge gives IDLE, `stall_count`=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Control FSM for the fetch stage. Sequences boot, normal
//               fetch, hazard stalls, branch redirects with a wrong-path
//               squash window and HALT detection, and keeps saturating
//               stall/redirect performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                INSTR_WIDTH  = 32,
    parameter int                OPCODE_W     = 5,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = 5'h1F,
    parameter int                BOOT_CYCLES  = 4,
    parameter int                FLUSH_CYCLES = 2,
    parameter int                CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall_req,
    input  logic                   branch_req,
    input  logic [INSTR_WIDTH-1:0] branch_target,
    input  logic                   instr_valid,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic                   fetch_en,
    output logic                   isBranchTaken,
    output logic [INSTR_WIDTH-1:0] branchPC,
    output logic                   squash,
    output logic                   halted,
    output logic                   busy,
    output logic [CNT_W-1:0]       stall_count,
    output logic [CNT_W-1:0]       flush_count
);

    // One down-counter serves both the boot delay and the squash window,
    // so it is sized for whichever reload value is larger.
    localparam int c_CNT_MAX = (BOOT_CYCLES > FLUSH_CYCLES) ? (BOOT_CYCLES - 1)
                                                            : (FLUSH_CYCLES - 1);
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_BOOT_LOAD  = c_CNT_W'(BOOT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_FLUSH_LOAD = c_CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BOOT  = 3'd1,
        S_RUN   = 3'd2,
        S_STALL = 3'd3,
        S_FLUSH = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_fetch_en;
    logic                   r_is_branch;
    logic [INSTR_WIDTH-1:0] r_branch_pc;
    logic                   r_squash;
    logic                   r_halted;
    logic                   r_busy;
    logic [CNT_W-1:0]       r_stall_count;
    logic [CNT_W-1:0]       r_flush_count;

    logic [OPCODE_W-1:0]    w_opcode;
    logic                   w_is_halt;

    // HALT is recognised only on a genuinely fetched instruction.
    assign w_opcode  = instr_in[INSTR_WIDTH-1 -: OPCODE_W];
    assign w_is_halt = instr_valid && (w_opcode == HALT_OPCODE);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Sequencer state machine; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_fetch_en    <= 1'b0;
            r_is_branch   <= 1'b0;
            r_branch_pc   <= '0;
            r_squash      <= 1'b0;
            r_halted      <= 1'b0;
            r_busy        <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            // The redirect pulse lasts a single cycle.
            r_is_branch <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_cnt         <= c_BOOT_LOAD;
                        r_stall_count <= '0;
                        r_flush_count <= '0;
                        r_halted      <= 1'b0;
                        r_busy        <= 1'b1;
                        r_fetch_en    <= 1'b0;
                        r_state       <= S_BOOT;
                    end
                end
                S_BOOT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_fetch_en <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (branch_req) begin
                        r_is_branch   <= 1'b1;
                        r_branch_pc   <= branch_target;
                        r_squash      <= 1'b1;
                        r_cnt         <= c_FLUSH_LOAD;
                        r_flush_count <= sat_inc(r_flush_count);
                        r_state       <= S_FLUSH;
                    end else if (w_is_halt) begin
                        r_fetch_en <= 1'b0;
                        r_halted   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_HALT;
                    end else if (stall_req) begin
                        r_fetch_en    <= 1'b0;
                        r_stall_count <= sat_inc(r_stall_count);
                        r_state       <= S_STALL;
                    end
                end
                S_STALL: begin
                    if (branch_req) begin
                        r_fetch_en    <= 1'b1;
                        r_is_branch   <= 1'b1;
                        r_branch_pc   <= branch_target;
                        r_squash      <= 1'b1;
                        r_cnt         <= c_FLUSH_LOAD;
                        r_flush_count <= sat_inc(r_flush_count);
                        r_state       <= S_FLUSH;
                    end else if (stall_req) begin
                        r_stall_count <= sat_inc(r_stall_count);
                    end else begin
                        r_fetch_en <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    // Everything seen here is wrong-path and is ignored.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_squash <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                default: begin
                    r_fetch_en <= 1'b0;
                    r_squash   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign fetch_en      = r_fetch_en;
    assign isBranchTaken = r_is_branch;
    assign branchPC      = r_branch_pc;
    assign squash        = r_squash;
    assign halted        = r_halted;
    assign busy          = r_busy;
    assign stall_count   = r_stall_count;
    assign flush_count   = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed scoreboard bench for fetch_sequencer. Expected
//               outputs are queued as each step is driven and compared just
//               after the following clock edge. A second instance with a
//               4-bit counter width shares the stimulus for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int c_F_FE  = 0;
    localparam int c_F_BT  = 1;
    localparam int c_F_PC  = 2;
    localparam int c_F_SQ  = 3;
    localparam int c_F_HA  = 4;
    localparam int c_F_BU  = 5;
    localparam int c_F_SC  = 6;
    localparam int c_F_FC  = 7;
    localparam int c_F_SC4 = 8;
    localparam int c_F_FC4 = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall_req;
    logic        branch_req;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr_in;

    logic        fetch_en, is_bt, squash, halted, busy;
    logic [31:0] branch_pc;
    logic [15:0] stall_count, flush_count;

    logic        fetch_en4, is_bt4, squash4, halted4, busy4;
    logic [31:0] branch_pc4;
    logic [3:0]  stall_count4, flush_count4;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string       tag;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    fetch_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .stall_req(stall_req),
        .branch_req(branch_req), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_in(instr_in),
        .fetch_en(fetch_en), .isBranchTaken(is_bt), .branchPC(branch_pc),
        .squash(squash), .halted(halted), .busy(busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    fetch_sequencer #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .stall_req(stall_req),
        .branch_req(branch_req), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_in(instr_in),
        .fetch_en(fetch_en4), .isBranchTaken(is_bt4), .branchPC(branch_pc4),
        .squash(squash4), .halted(halted4), .busy(busy4),
        .stall_count(stall_count4), .flush_count(flush_count4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int fld);
        case (fld)
            c_F_FE:  return {31'd0, fetch_en};
            c_F_BT:  return {31'd0, is_bt};
            c_F_PC:  return branch_pc;
            c_F_SQ:  return {31'd0, squash};
            c_F_HA:  return {31'd0, halted};
            c_F_BU:  return {31'd0, busy};
            c_F_SC:  return {16'd0, stall_count};
            c_F_FC:  return {16'd0, flush_count};
            c_F_SC4: return {28'd0, stall_count4};
            c_F_FC4: return {28'd0, flush_count4};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int fld, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic expect_all(input string tag, input logic fe, input logic bt,
                              input logic [31:0] pc, input logic sq, input logic ha,
                              input logic bu, input logic [15:0] sc, input logic [15:0] fc);
        expect_out({tag, ".fetch_en"}, c_F_FE, {31'd0, fe});
        expect_out({tag, ".isBranchTaken"}, c_F_BT, {31'd0, bt});
        expect_out({tag, ".branchPC"}, c_F_PC, pc);
        expect_out({tag, ".squash"}, c_F_SQ, {31'd0, sq});
        expect_out({tag, ".halted"}, c_F_HA, {31'd0, ha});
        expect_out({tag, ".busy"}, c_F_BU, {31'd0, bu});
        expect_out({tag, ".stall_count"}, c_F_SC, {16'd0, sc});
        expect_out({tag, ".flush_count"}, c_F_FC, {16'd0, fc});
    endtask

    // Advance one edge, then drain and compare everything queued for it.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.fld);
            n_total = n_total + 1;
            assert (obs === e.exp) n_pass = n_pass + 1;
            else $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stall_req = 1'b0; branch_req = 1'b0;
        branch_target = 32'd0; instr_valid = 1'b0; instr_in = 32'd0;

        // Reset held low for three edges.
        tick();
        tick();
        expect_all("reset", 0, 0, 32'h0, 0, 0, 0, 16'd0, 16'd0);
        expect_out("reset.stall_count4", c_F_SC4, 32'd0);
        tick();

        // Boot: start at edge 0, fetch_en rises after edge 4.
        rst = 1'b1; start = 1'b1;
        expect_out("boot0.busy", c_F_BU, 32'd1);
        expect_out("boot0.fetch_en", c_F_FE, 32'd0);
        tick();
        start = 1'b0;
        tick();
        tick();
        expect_out("boot3.fetch_en", c_F_FE, 32'd0);
        expect_out("boot3.busy", c_F_BU, 32'd1);
        tick();
        expect_all("boot4", 1, 0, 32'h0, 0, 0, 1, 16'd0, 16'd0);
        tick();

        // Redirect to 0x40; stall_req during FLUSH must not count.
        branch_req = 1'b1; branch_target = 32'h40;
        expect_all("redir", 1, 1, 32'h40, 1, 0, 1, 16'd0, 16'd1);
        expect_out("redir.flush_count4", c_F_FC4, 32'd1);
        tick();
        branch_req = 1'b0; branch_target = 32'h99; stall_req = 1'b1;
        expect_all("flush1", 1, 0, 32'h40, 1, 0, 1, 16'd0, 16'd1);
        tick();
        expect_all("flush2", 1, 0, 32'h40, 0, 0, 1, 16'd0, 16'd1);
        tick();
        stall_req = 1'b0;
        expect_out("postflush.fetch_en", c_F_FE, 32'd1);
        tick();

        // Five-cycle stall.
        stall_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            expect_out($sformatf("stall%0d.fetch_en", i), c_F_FE, 32'd0);
            expect_out($sformatf("stall%0d.stall_count", i), c_F_SC, 32'(i));
            tick();
        end
        stall_req = 1'b0;
        expect_all("unstall", 1, 0, 32'h40, 0, 0, 1, 16'd5, 16'd1);
        expect_out("unstall.stall_count4", c_F_SC4, 32'd5);
        tick();

        // Branch, stall and HALT together: the branch wins.
        branch_req = 1'b1; stall_req = 1'b1; branch_target = 32'h80;
        instr_valid = 1'b1; instr_in = 32'hF800_0000;
        expect_all("prio", 1, 1, 32'h80, 1, 0, 1, 16'd5, 16'd2);
        tick();
        branch_req = 1'b0; stall_req = 1'b0;
        expect_out("prioflush1.halted", c_F_HA, 32'd0);
        expect_out("prioflush1.squash", c_F_SQ, 32'd1);
        tick();
        expect_all("prioflush2", 1, 0, 32'h80, 0, 0, 1, 16'd5, 16'd2);
        tick();

        // HALT opcode now taken from RUN.
        expect_all("halt", 0, 0, 32'h80, 0, 1, 0, 16'd5, 16'd2);
        tick();
        instr_valid = 1'b0; branch_req = 1'b1; branch_target = 32'h123;
        expect_all("halt_ign", 0, 0, 32'h80, 0, 1, 0, 16'd5, 16'd2);
        tick();
        branch_req = 1'b0;

        // Restart from HALT.
        start = 1'b1;
        expect_all("restart", 0, 0, 32'h80, 0, 0, 1, 16'd0, 16'd0);
        tick();
        start = 1'b0;
        tick();
        tick();
        expect_out("restart3.fetch_en", c_F_FE, 32'd0);
        tick();
        expect_out("restart4.fetch_en", c_F_FE, 32'd1);
        tick();

        // Branch taken out of STALL resumes fetch without counting a stall.
        stall_req = 1'b1;
        expect_out("stb1.fetch_en", c_F_FE, 32'd0);
        expect_out("stb1.stall_count", c_F_SC, 32'd1);
        tick();
        branch_req = 1'b1; branch_target = 32'h1234;
        expect_all("stb2", 1, 1, 32'h1234, 1, 0, 1, 16'd1, 16'd1);
        tick();
        branch_req = 1'b0; stall_req = 1'b0;
        tick();
        expect_out("stb4.squash", c_F_SQ, 32'd0);
        tick();

        // Twenty stall cycles saturate the 4-bit counter only.
        stall_req = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        expect_out("sat.stall_count4", c_F_SC4, 32'hF);
        expect_out("sat.stall_count", c_F_SC, 32'd21);
        expect_out("sat.fetch_en", c_F_FE, 32'd0);
        tick();

        // Reset during STALL, with start also high: reset wins.
        rst = 1'b0; start = 1'b1;
        expect_all("rst_mid", 0, 0, 32'h0, 0, 0, 0, 16'd0, 16'd0);
        expect_out("rst_mid.stall_count4", c_F_SC4, 32'd0);
        tick();
        rst = 1'b1; start = 1'b0; stall_req = 1'b0;
        expect_out("idle.busy", c_F_BU, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
